// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, addresses the instruction ROM
// and registers fetched words into the IF/ID handshake register.
module fetch_unit #(
    parameter int unsigned PC_WIDTH    = 32,
    parameter int unsigned ADDR_WIDTH  = 16,
    parameter int unsigned INSTR_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic [ADDR_WIDTH-1:0]  rom_addr,
    input  logic [INSTR_WIDTH-1:0] rom_data,
    input  logic                   redirect_valid,
    input  logic [PC_WIDTH-1:0]    redirect_pc,
    input  logic                   halt_req,
    input  logic                   resume,
    input  logic                   id_ready,
    output logic                   if_valid,
    output logic [PC_WIDTH-1:0]    if_pc,
    output logic [INSTR_WIDTH-1:0] if_instr,
    output logic                   halted,
    output logic [31:0]            fetch_count
);

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HALT
    } state_t;

    localparam logic [PC_WIDTH-1:0] PC_MASK = ~PC_WIDTH'(3);

    state_t                 state_q, state_d;
    logic [PC_WIDTH-1:0]    pc_q, pc_d;
    logic                   valid_q, valid_d;
    logic [PC_WIDTH-1:0]    ipc_q, ipc_d;
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic [31:0]            cnt_q;
    logic                   xfer;
    logic                   slot_free;
    logic                   fetch;

    assign xfer      = valid_q & id_ready;
    assign slot_free = ~valid_q | id_ready;

    assign rom_addr    = pc_q[ADDR_WIDTH+1:2];
    assign if_valid    = valid_q;
    assign if_pc       = ipc_q;
    assign if_instr    = instr_q;
    assign halted      = (state_q == HALT);
    assign fetch_count = cnt_q;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        valid_d = valid_q & ~id_ready;
        ipc_d   = ipc_q;
        instr_d = instr_q;
        fetch   = 1'b0;
        // Redirect first, then state; halt_req only matters in RUN.
        priority case (1'b1)
            redirect_valid: begin
                pc_d    = redirect_pc & PC_MASK;
                valid_d = 1'b0;
                state_d = RUN;
            end
            state_q == BOOT: state_d = RUN;
            state_q == HALT: if (resume) state_d = RUN;
            halt_req:        state_d = HALT;
            default:         fetch = slot_free;
        endcase
        if (fetch) begin
            pc_d    = pc_q + PC_WIDTH'(4);
            ipc_d   = pc_q;
            instr_d = rom_data;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC & PC_MASK;
            valid_q <= 1'b0;
            ipc_q   <= '0;
            instr_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            ipc_q   <= ipc_d;
            instr_q <= instr_d;
            if (xfer) cnt_q <= cnt_q + 32'd1;
        end
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage that owns the program counter, drives the word address of the combinational instruction ROM (`rom`), and registers the returned instruction into the IF/ID pipeline register. It handles decode backpressure with a valid/ready handshake, control-flow redirects from execute, and halt/resume requests. It also keeps a retired-fetch counter for bring-up.

## Interface
- `PC_WIDTH`, 32: program counter width, byte address.
- `ADDR_WIDTH`, 16: ROM word-address width; matches ROM `INPUT_SIZE`.
- `INSTR_WIDTH`, 32: instruction width; matches ROM `OUTPUT_SIZE`.
- `RESET_PC`, 0: PC loaded at reset; bits [1:0] must be 0.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rom_addr`  out  ADDR_WIDTH  `pc[ADDR_WIDTH+1:2]`, combinational from the PC register.
- `rom_data`  in  INSTR_WIDTH  ROM `spo`; valid in the same cycle as `rom_addr`.
- `redirect_valid`  in  1  branch/jump taken; flushes the stage.
- `redirect_pc`  in  PC_WIDTH  redirect target; bits [1:0] ignored.
- `halt_req`  in  1  stop fetching (one-cycle pulse or level).
- `resume`  in  1  leave HALT, continue from the current PC.
- `id_ready`  in  1  decode accepts `if_*` this cycle.
- `if_valid`  out  1  `if_pc`/`if_instr` hold a valid instruction.
- `if_pc`  out  PC_WIDTH  byte address of `if_instr`.
- `if_instr`  out  INSTR_WIDTH  fetched instruction.
- `halted`  out  1  high while in HALT.
- `fetch_count`  out  32  number of completed IF→ID handshakes; wraps.

## Operation
- The state machine has three states: BOOT, RUN and HALT. Reset enters BOOT.
- Reset values:
  - `pc` = RESET_PC, with `pc[1:0]` held at 0 at all times.
  - `if_valid` = 0, `if_pc` = 0, `if_instr` = 0.
  - `halted` = 0, `fetch_count` = 0.
- BOOT: held for exactly one cycle with no fetch, then moves to RUN. A redirect in BOOT is honoured as in RUN.
- Handshake: a transfer occurs on any edge where `if_valid && id_ready`. `if_*` stay stable while `if_valid && !id_ready`.
- Slot free means `!if_valid || id_ready`.
- RUN, slot free, no redirect, no `halt_req`:
  - `if_instr` <= `rom_data`, `if_pc` <= `pc`, `if_valid` <= 1.
  - `pc` <= `pc` + 4, modulo 2^PC_WIDTH.
- RUN, slot not free: `pc` and `if_*` hold.
- `halt_req` in RUN with no redirect:
  - No new fetch that edge; the state moves to HALT.
  - Any pending `if_*` stays until transferred, then `if_valid` <= 0.
  - `pc` points to the next unfetched instruction.
- HALT:
  - `halted` = 1 and nothing is fetched.
  - `resume` moves to RUN and fetching restarts at the held `pc` on the following edge.
  - `halt_req` has no effect in HALT.
- Redirect has the highest priority in every state:
  - `pc` <= {`redirect_pc[PC_WIDTH-1:2]`, 2'b00}.
  - `if_valid` <= 0, state <= RUN.
  - It overrides a simultaneous `halt_req`, `resume` or fetch.
- `fetch_count` increments on every transfer, including a transfer in the same cycle as a redirect. The counter wraps from 0xFFFFFFFF to 0.
- Addresses beyond the ROM depth are not checked; `rom_addr` truncation defines the behaviour.

## Timing
- `rom_addr` changes only after a clock edge or reset, as a combinational function of `pc`.
- Throughput: one instruction per cycle while `id_ready` = 1 in RUN.
- Reset release to first valid instruction:
  - Edge 1 leaves BOOT.
  - Edge 2 sets `if_valid` = 1 with `if_pc` = RESET_PC.
- Redirect latency:
  - `redirect_valid` sampled at edge N sets `pc` = target and `if_valid` = 0.
  - At edge N+1, `if_valid` = 1 with `if_pc` = target (if RUN and not halted).
- Resume latency: `resume` at edge N moves to RUN. The next instruction appears at edge N+1.
- Asynchronous reset mid-stream:
  - All outputs go to their reset values immediately.
  - No partial handshake is counted.

## Test plan
- Reset then free-run, ROM preloaded with mem[i] = i, `id_ready` = 1:
  - `if_valid` rises at the 2nd edge with `if_pc` = 0x0, `if_instr` = 0.
  - It is then followed by 0x4/1, 0x8/2, … one per cycle.
  - After 10 transfers `fetch_count` = 10.
- Backpressure: drop `id_ready` for 3 cycles while `if_pc` = 0x8:
  - `if_pc`/`if_instr` stay 0x8/2 and `rom_addr` stays 3.
  - On release, 0xC/3 follows with no skip or duplicate.
- Redirect to 0x41 while `if_valid` = 1 and `id_ready` = 0:
  - The next edge gives `if_valid` = 0 and `rom_addr` = 0x10.
  - The following edge gives `if_pc` = 0x40, `if_instr` = 0x10.
  - `fetch_count` is unchanged.
- Halt at `if_pc` = 0x4, then `resume` 5 cycles later:
  - `halted` = 1 and `if_valid` falls after the 0x4 transfer.
  - On resume, the next instruction is 0x8/2.
  - Also apply `redirect_valid` together with `halt_req`: the redirect wins and `halted` stays 0.
- Assert `rst_n` = 0 mid-run while `if_valid` = 1:
  - Immediately `if_valid` = 0, `fetch_count` = 0 and `rom_addr` = RESET_PC>>2.
  - The BOOT sequence repeats.
- Wrap-around:
  - Redirect to 0xFFFFFFFC with PC_WIDTH = 32; after that fetch, `pc` wraps to 0x0.
  - Preload `fetch_count` via 2^32−1 transfers, or force the count in simulation; the next transfer gives 0.
